// File: rtl/axi_burst_master.sv
// ----------------------------------------------------------------------------
// axi_burst_master
//   AXI4 initiator: each accepted command becomes exactly one INCR burst.
//   One transaction is in flight at a time. Bursts that would cross a 4 KiB
//   page are rejected without any AXI traffic.
//
//   Ports
//     clk_i, rst_i       clock, synchronous active-high reset
//     cmd_*              command stream (write flag, start address, len)
//     wdata_*, wstrb_i   write data stream, passed straight through to W
//     rdata_*            read data stream, passed straight through from R
//     done_o, err_o      one-cycle completion pulse with error flag
//     axi_req_o          AXI4 request (AW, W, B ready, AR, R ready)
//     axi_rsp_i          AXI4 response
// ----------------------------------------------------------------------------
package axi_burst_pkg;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic          lock;
        logic [3:0]    cache;
        logic [2:0]    prot;
        logic [3:0]    qos;
        logic [3:0]    region;
        logic [UW-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
        logic [UW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic [UW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [UW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;
endpackage

module axi_burst_master #(
    parameter int unsigned        AddrWidth = 32,
    parameter int unsigned        DataWidth = 64,
    parameter int unsigned        IdWidth   = 4,
    parameter int unsigned        UserWidth = 1,
    parameter logic [IdWidth-1:0] AxiId     = '0,
    parameter type                req_t     = axi_burst_pkg::axi_req_t,
    parameter type                rsp_t     = axi_burst_pkg::axi_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic [7:0]             cmd_len_i,
    input  logic                   wdata_valid_i,
    output logic                   wdata_ready_o,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    output logic                   rdata_valid_o,
    input  logic                   rdata_ready_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   rdata_last_o,
    output logic                   done_o,
    output logic                   err_o,
    output req_t                   axi_req_o,
    input  rsp_t                   axi_rsp_i
);
    localparam int unsigned          Bytes     = DataWidth / 8;
    localparam logic [2:0]           AxSize    = 3'($clog2(Bytes));
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(Bytes - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic [AddrWidth-1:0]   aligned_addr;
    logic [31:0]            span;
    logic                   crosses_4k;
    logic                   cnt_at_len;
    logic                   b_bad, r_bad;
    logic [UserWidth-1:0]   unused_user;

    assign aligned_addr = cmd_addr_i & AlignMask;
    // Offset inside the page plus burst size; exactly 4096 still fits.
    assign span         = 32'(aligned_addr[11:0]) + (32'(cmd_len_i) + 32'd1) * 32'(Bytes);
    assign crosses_4k   = span > 32'd4096;
    assign cnt_at_len   = cnt_q == len_q;
    assign b_bad        = (axi_rsp_i.b.resp != axi_burst_pkg::RESP_OKAY) || (axi_rsp_i.b.id != AxiId);
    assign r_bad        = (axi_rsp_i.r.resp != axi_burst_pkg::RESP_OKAY) || (axi_rsp_i.r.id != AxiId);
    assign unused_user  = axi_rsp_i.b.user ^ axi_rsp_i.r.user;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d = aligned_addr;
                    len_d  = cmd_len_i;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (crosses_4k) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = cmd_write_i ? ST_AW : ST_AR;
                    end
                end
            end
            ST_AW: if (axi_rsp_i.aw_ready) state_d = ST_W;
            ST_AR: if (axi_rsp_i.ar_ready) state_d = ST_R;
            ST_W: begin
                if (wdata_valid_i && axi_rsp_i.w_ready) begin
                    // Hold the counter at len so it can never wrap.
                    if (cnt_at_len) state_d = ST_B;
                    else            cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_B: begin
                if (axi_rsp_i.b_valid) begin
                    if (b_bad) err_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_R: begin
                if (axi_rsp_i.r_valid && rdata_ready_i) begin
                    if (r_bad) err_d = 1'b1;
                    // Either the slave's last or our own count ends the burst;
                    // disagreement between them is a protocol error.
                    if (axi_rsp_i.r.last || cnt_at_len) begin
                        if (axi_rsp_i.r.last != cnt_at_len) err_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state; W and R are pass-through.
    always_comb begin
        axi_req_o     = '0;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_valid_o = 1'b0;
        rdata_o       = '0;
        rdata_last_o  = 1'b0;
        done_o        = 1'b0;
        err_o         = 1'b0;
        unique case (state_q)
            ST_IDLE: cmd_ready_o = 1'b1;
            ST_AW: begin
                axi_req_o.aw_valid = 1'b1;
                axi_req_o.aw.id    = AxiId;
                axi_req_o.aw.addr  = addr_q;
                axi_req_o.aw.len   = len_q;
                axi_req_o.aw.size  = AxSize;
                axi_req_o.aw.burst = axi_burst_pkg::BURST_INCR;
            end
            ST_W: begin
                axi_req_o.w_valid  = wdata_valid_i;
                axi_req_o.w.data   = wdata_i;
                axi_req_o.w.strb   = wstrb_i;
                axi_req_o.w.last   = cnt_at_len;
                wdata_ready_o      = axi_rsp_i.w_ready;
            end
            ST_B: axi_req_o.b_ready = 1'b1;
            ST_AR: begin
                axi_req_o.ar_valid = 1'b1;
                axi_req_o.ar.id    = AxiId;
                axi_req_o.ar.addr  = addr_q;
                axi_req_o.ar.len   = len_q;
                axi_req_o.ar.size  = AxSize;
                axi_req_o.ar.burst = axi_burst_pkg::BURST_INCR;
            end
            ST_R: begin
                axi_req_o.r_ready  = rdata_ready_i;
                rdata_valid_o      = axi_rsp_i.r_valid;
                rdata_o            = axi_rsp_i.r.data;
                rdata_last_o       = axi_rsp_i.r.last;
            end
            ST_DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI slave with memory, a reference
// memory built from the commands issued, and directed plus random scenarios.
module tb_axi_burst_master;
    import axi_burst_pkg::*;

    localparam logic [3:0] ID = 4'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wdata_valid = 1'b0, wdata_ready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        rdata_valid, rdata_ready = 1'b0, rdata_last;
    logic [63:0] rdata;
    logic        done, err;
    axi_req_t    req;
    axi_rsp_t    rsp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_burst_master #(
        .AddrWidth(32), .DataWidth(64), .IdWidth(4), .UserWidth(1), .AxiId(ID),
        .req_t(axi_req_t), .rsp_t(axi_rsp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
        .wdata_i(wdata), .wstrb_i(wstrb),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready),
        .rdata_o(rdata), .rdata_last_o(rdata_last),
        .done_o(done), .err_o(err),
        .axi_req_o(req), .axi_rsp_i(rsp)
    );

    // ---------------- memories: slave storage and reference model ----------
    logic [63:0] slv_mem [logic [31:0]];
    logic [63:0] ref_mem [logic [31:0]];

    function automatic logic [63:0] init_pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] slv_word(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_pat(a);
    endfunction

    function automatic logic [63:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    endfunction

    // ---------------- behavioural AXI slave + traffic log -------------------
    bit          slv_stall = 1'b0;
    bit          slv_bad_id = 1'b0;
    int          slv_err_beat = -1;
    int          aw_valid_cycles = 0;
    int          proto_viol = 0;
    ax_chan_t    aw_log[$];
    ax_chan_t    ar_log[$];
    w_chan_t     w_log[$];

    initial begin : slave
        axi_req_t    s_req;
        axi_rsp_t    s_rsp;
        bit          s_rst;
        bit          wr_active, b_pend, rd_active;
        logic [31:0] wr_addr, rd_addr;
        int          wr_beat, rd_beat, rd_len;
        wr_active = 0; b_pend = 0; rd_active = 0;
        wr_addr = '0; rd_addr = '0; wr_beat = 0; rd_beat = 0; rd_len = 0;
        rsp = '0;
        forever begin
            @(negedge clk);
            s_req = req; s_rsp = rsp; s_rst = rst;
            @(posedge clk); #1;
            if (s_rst) begin
                wr_active = 0; b_pend = 0; rd_active = 0;
                rsp = '0;
                continue;
            end
            if (s_req.aw_valid) aw_valid_cycles++;
            if (s_req.aw_valid && s_req.ar_valid) proto_viol++;
            if (s_req.w_valid && !wr_active) proto_viol++;
            if (s_req.w_valid && s_rsp.w_ready && wr_active) begin
                w_log.push_back(s_req.w);
                slv_mem[wr_addr + 32'(wr_beat * 8)] =
                    merge(slv_word(wr_addr + 32'(wr_beat * 8)), s_req.w.data, s_req.w.strb);
                wr_beat++;
                if (s_req.w.last) begin
                    wr_active = 0;
                    b_pend    = 1;
                end
            end
            if (s_rsp.b_valid && s_req.b_ready) b_pend = 0;
            if (s_req.aw_valid && s_rsp.aw_ready) begin
                aw_log.push_back(s_req.aw);
                wr_active = 1; wr_addr = s_req.aw.addr; wr_beat = 0;
            end
            if (s_req.ar_valid && s_rsp.ar_ready) begin
                ar_log.push_back(s_req.ar);
                rd_active = 1; rd_addr = s_req.ar.addr; rd_len = int'(s_req.ar.len); rd_beat = 0;
            end else if (rd_active && s_rsp.r_valid && s_req.r_ready) begin
                rd_beat++;
                if (rd_beat > rd_len) rd_active = 0;
            end
            rsp.aw_ready = slv_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp.ar_ready = slv_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp.w_ready  = slv_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp.b_valid  = b_pend;
            rsp.b.id     = slv_bad_id ? ~ID : ID;
            rsp.b.resp   = 2'b00;
            rsp.b.user   = '0;
            rsp.r_valid  = rd_active;
            rsp.r.id     = slv_bad_id ? ~ID : ID;
            rsp.r.data   = rd_active ? slv_word(rd_addr + 32'(rd_beat * 8)) : '0;
            rsp.r.last   = rd_active && (rd_beat == rd_len);
            rsp.r.resp   = (rd_active && rd_beat == slv_err_beat) ? 2'b10 : 2'b00;
            rsp.r.user   = '0;
        end
    end

    // ---------------- command driver ---------------------------------------
    logic [63:0] wd_q[$];
    logic [7:0]  ws_q[$];
    logic [63:0] rd_data_q[$];
    bit          rd_last_q[$];

    // rmode: 0 = always ready, 1 = toggle every cycle, 2 = random
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input int rmode, input bit gaps,
                           output bit got_done, output bit got_err, output int lat);
        int  c0, wi;
        bit  cmd_hs, wd_hs, rd_hs;
        got_done = 0; got_err = 0; lat = -1; c0 = -1; wi = 0;
        rd_data_q.delete(); rd_last_q.delete();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        wdata_valid = wr && (!gaps || $urandom_range(0, 1) == 1);
        if (wr) begin wdata = wd_q[0]; wstrb = ws_q[0]; end
        rdata_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            @(negedge clk);
            cmd_hs = cmd_valid && cmd_ready;
            wd_hs  = wdata_valid && wdata_ready;
            rd_hs  = rdata_valid && rdata_ready;
            if (cmd_hs) c0 = cyc;
            if (rdata_valid) begin
                checks++;
                if (req.r_ready !== rdata_ready) begin
                    errors++;
                    $display("FAIL r_ready_mirror: r_ready=%b rdata_ready_i=%b", req.r_ready, rdata_ready);
                end
            end
            if (rd_hs) begin
                rd_data_q.push_back(rdata);
                rd_last_q.push_back(rdata_last);
            end
            if (done) begin
                got_done = 1; got_err = err; lat = cyc - c0;
            end
            @(posedge clk); #1;
            if (cmd_hs) cmd_valid = 1'b0;
            if (wd_hs) wi++;
            wdata_valid = wr && (wi <= int'(len)) && (!gaps || $urandom_range(0, 1) == 1);
            if (wr && wi <= int'(len)) begin wdata = wd_q[wi]; wstrb = ws_q[wi]; end
            case (rmode)
                1:       rdata_ready = ~rdata_ready;
                2:       rdata_ready = 1'($urandom_range(0, 1));
                default: rdata_ready = 1'b1;
            endcase
        end
        cmd_valid = 1'b0; wdata_valid = 1'b0;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL done_timeout: done_o never seen for addr=%h len=%0d", addr, len);
        end else begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_width: done_o=%b one cycle after pulse, expected 0", done);
            end
        end
    endtask

    // Issue one command and check everything the spec rules predict for it.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                          input int rmode, input bit gaps, input bit inj_err, output int lat);
        logic [31:0] base;
        bit          crosses, got_done, got_err;
        int          aw0, w0, ar0, awv0, nbeats;
        ax_chan_t    ax;
        w_chan_t     wb;
        base    = addr & ~32'h7;
        nbeats  = int'(len) + 1;
        crosses = (int'(base[11:0]) + nbeats * 8) > 4096;
        wd_q.delete(); ws_q.delete();
        if (wr) begin
            for (int i = 0; i < nbeats; i++) begin
                wd_q.push_back({$urandom, $urandom});
                ws_q.push_back(8'($urandom));
            end
        end
        aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size(); awv0 = aw_valid_cycles;
        run_cmd(wr, addr, len, rmode, gaps, got_done, got_err, lat);
        if (!got_done) return;
        checks++;
        if (got_err !== (crosses || inj_err)) begin
            errors++;
            $display("FAIL err_flag: addr=%h len=%0d err_o=%b expected %b", addr, len, got_err, crosses || inj_err);
        end
        if (crosses) begin
            checks++;
            if (aw_log.size() != aw0 || ar_log.size() != ar0 || aw_valid_cycles != awv0) begin
                errors++;
                $display("FAIL reject_traffic: aw=%0d ar=%0d awv=%0d cycles, expected none",
                         aw_log.size() - aw0, ar_log.size() - ar0, aw_valid_cycles - awv0);
            end
        end else if (wr) begin
            checks++;
            if (aw_log.size() != aw0 + 1) begin
                errors++;
                $display("FAIL aw_count: got %0d AW handshakes, expected 1", aw_log.size() - aw0);
            end else begin
                ax = aw_log[aw0];
                checks++;
                if (ax.addr !== base || ax.len !== len || ax.size !== 3'd3 || ax.burst !== 2'b01 || ax.id !== ID) begin
                    errors++;
                    $display("FAIL aw_fields: addr=%h len=%0d size=%0d burst=%0d id=%0d expected %h %0d 3 1 %0d",
                             ax.addr, ax.len, ax.size, ax.burst, ax.id, base, len, ID);
                end
            end
            checks++;
            if (w_log.size() - w0 != nbeats) begin
                errors++;
                $display("FAIL w_count: got %0d W beats, expected %0d", w_log.size() - w0, nbeats);
            end
            for (int i = 0; i < nbeats && w0 + i < w_log.size(); i++) begin
                wb = w_log[w0 + i];
                checks++;
                if (wb.data !== wd_q[i] || wb.strb !== ws_q[i] || wb.last !== (i == nbeats - 1)) begin
                    errors++;
                    $display("FAIL w_beat%0d: data=%h strb=%h last=%b expected %h %h %b",
                             i, wb.data, wb.strb, wb.last, wd_q[i], ws_q[i], i == nbeats - 1);
                end
            end
            for (int i = 0; i < nbeats; i++)
                ref_mem[base + 32'(i * 8)] = merge(ref_word(base + 32'(i * 8)), wd_q[i], ws_q[i]);
        end else begin
            checks++;
            if (ar_log.size() != ar0 + 1) begin
                errors++;
                $display("FAIL ar_count: got %0d AR handshakes, expected 1", ar_log.size() - ar0);
            end else begin
                ax = ar_log[ar0];
                checks++;
                if (ax.addr !== base || ax.len !== len || ax.size !== 3'd3 || ax.burst !== 2'b01 || ax.id !== ID) begin
                    errors++;
                    $display("FAIL ar_fields: addr=%h len=%0d size=%0d burst=%0d id=%0d expected %h %0d 3 1 %0d",
                             ax.addr, ax.len, ax.size, ax.burst, ax.id, base, len, ID);
                end
            end
            checks++;
            if (rd_data_q.size() != nbeats) begin
                errors++;
                $display("FAIL r_count: got %0d beats, expected %0d", rd_data_q.size(), nbeats);
            end
            for (int i = 0; i < nbeats && i < rd_data_q.size(); i++) begin
                checks++;
                if (rd_data_q[i] !== ref_word(base + 32'(i * 8)) || rd_last_q[i] !== (i == nbeats - 1)) begin
                    errors++;
                    $display("FAIL r_beat%0d: data=%h last=%b expected %h %b", i, rd_data_q[i],
                             rd_last_q[i], ref_word(base + 32'(i * 8)), i == nbeats - 1);
                end
            end
        end
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req !== '0 || done !== 1'b0 || rdata_valid !== 1'b0 || wdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%h done=%b rvalid=%b wready=%b expected all 0",
                     req, done, rdata_valid, wdata_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || req !== '0) begin
            errors++;
            $display("FAIL reset_idle: cmd_ready=%b req=%h expected 1 and 0", cmd_ready, req);
        end
    endtask

    task automatic test_latency();
        int lat;
        do_txn(1'b1, 32'h1100, 8'd0, 0, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL write_latency: got %0d cycles, expected 4", lat);
        end
        do_txn(1'b0, 32'h1100, 8'd0, 0, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL read_latency: got %0d cycles, expected 3", lat);
        end
    endtask

    task automatic test_write_readback();
        int lat;
        do_txn(1'b1, 32'h1000, 8'd3, 0, 1'b0, 1'b0, lat);
        do_txn(1'b0, 32'h1000, 8'd3, 0, 1'b0, 1'b0, lat);
    endtask

    task automatic test_read_unaligned();
        int lat;
        do_txn(1'b0, 32'h1007, 8'd0, 0, 1'b0, 1'b0, lat);
    endtask

    task automatic test_read_toggle();
        int lat;
        do_txn(1'b0, 32'h1000, 8'd15, 1, 1'b0, 1'b0, lat);
    endtask

    task automatic test_4k_boundary();
        int lat;
        do_txn(1'b1, 32'h0FF8, 8'd1, 0, 1'b0, 1'b0, lat);
        checks++;
        if (lat < 1 || lat > 2) begin
            errors++;
            $display("FAIL reject_latency: got %0d cycles, expected at most 2", lat);
        end
        do_txn(1'b1, 32'h0FF8, 8'd0, 0, 1'b0, 1'b0, lat);   // ends exactly at 4096: allowed
        do_txn(1'b0, 32'h1F00, 8'd63, 0, 1'b0, 1'b0, lat);  // read crossing: rejected
    endtask

    task automatic test_slverr_and_id();
        int lat;
        slv_err_beat = 2;
        do_txn(1'b0, 32'h1000, 8'd3, 0, 1'b0, 1'b1, lat);
        slv_err_beat = -1;
        slv_bad_id = 1'b1;
        do_txn(1'b1, 32'h1200, 8'd1, 0, 1'b0, 1'b1, lat);
        do_txn(1'b0, 32'h1200, 8'd1, 0, 1'b0, 1'b1, lat);
        slv_bad_id = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int  beats, lat;
        bit  any_done;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5000; cmd_len = 8'd7;
        wdata_valid = 1'b0; wstrb = 8'hFF; wdata = 64'h1;
        @(posedge clk); #1;                 // handshake taken in IDLE
        cmd_valid = 1'b0;
        wdata_valid = 1'b1;
        beats = 0;
        for (int n = 0; n < 100 && beats < 3; n++) begin
            @(negedge clk);
            if (wdata_valid && wdata_ready) beats++;
            @(posedge clk); #1;
            wdata = 64'(n + 2);
        end
        wdata_valid = 1'b0;
        checks++;
        if (beats != 3) begin
            errors++;
            $display("FAIL midwrite_setup: got %0d beats accepted, expected 3", beats);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req.aw_valid !== 1'b0 || req.w_valid !== 1'b0 || req.ar_valid !== 1'b0 ||
            rdata_valid !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midwrite_reset: awv=%b wv=%b arv=%b rv=%b cmd_ready=%b done=%b expected 0 0 0 0 1 0",
                     req.aw_valid, req.w_valid, req.ar_valid, rdata_valid, cmd_ready, done);
        end
        any_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) any_done = 1;
        end
        checks++;
        if (any_done) begin
            errors++;
            $display("FAIL midwrite_no_done: done_o=1 seen after reset, expected none");
        end
        do_txn(1'b1, 32'h1800, 8'd1, 0, 1'b0, 1'b0, lat);
        do_txn(1'b0, 32'h1800, 8'd1, 0, 1'b0, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat;
        slv_stall = 1'b1;
        for (int i = 0; i < 30; i++) begin
            do_txn(1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 32'h1FFF)),
                   8'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), 1'b0, lat);
        end
        slv_stall = 1'b0;
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_viol != 0) begin
            errors++;
            $display("FAIL protocol: %0d violations (W before AW or AW/AR overlap), expected 0", proto_viol);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_write_readback();
        test_read_unaligned();
        test_read_toggle();
        test_4k_boundary();
        test_slverr_and_id();
        test_reset_mid_write();
        test_random();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
